core_regfile_scoreboard: RTL and testbench
==========================================

// Module: core_regfile_scoreboard
// PURPOSE
//  Issue-side controller for core_regfile: tracks in-flight writes per architectural register.
//  Stalls issue on RAW hazards and counter saturation, and drives the regfile read ports on each accepted issue.
//  Sits between decode (issue handshake) and core_regfile (rs0/rs1 read ports).
//  Writeback reports completions through the wb_* port.
// PARAMETERS
//  NREGS   32  number of architectural registers; x0 is hardwired zero and never busy
//  AW      5   register address width, $clog2(NREGS)
//  CNT_W   2   per-register pending counter width; CNT_MAX = 2**CNT_W-1
// PORTS
//  clk_i           in   1       core clock
//  rst_i           in   1       asynchronous reset, active-high
//  flush_i         in   1       pipeline flush; discards all pending state
//  iss_valid_i     in   1       decode presents an instruction
//  iss_ready_o     out  1       scoreboard accepts it; fire = iss_valid_i & iss_ready_o
//  iss_rs0_use_i   in   1       instruction reads rs0
//  iss_rs0_addr_i  in   AW      rs0 address
//  iss_rs1_use_i   in   1       instruction reads rs1
//  iss_rs1_addr_i  in   AW      rs1 address
//  iss_rd_we_i     in   1       instruction writes rd
//  iss_rd_addr_i   in   AW      rd address
//  wb_valid_i      in   1       one write to the regfile completes this cycle
//  wb_addr_i       in   AW      completed rd address
//  rs0_re_o        out  1       regfile read enable 0 = fire & iss_rs0_use_i
//  rs0_addr_o      out  AW      = iss_rs0_addr_i
//  rs1_re_o        out  1       regfile read enable 1 = fire & iss_rs1_use_i
//  rs1_addr_o      out  AW      = iss_rs1_addr_i
//  busy_o          out  NREGS   bit r = (cnt[r] != 0)
//  pend_total_o    out  AW+CNT_W  sum of all counters
//  err_o           out  1       sticky protocol error
// BEHAVIOUR
//  Reset: all cnt=0; busy_o=0; pend_total_o=0; err_o=0; iss_ready_o=0 while rst_i is high.
//  Reset asserted mid-operation clears all state immediately; in-flight writebacks are forgotten.
//  Hazards, all combinational:
//   - RAW on src s: use & addr!=0 & cnt[addr]!=0.
//   - Saturation: rd_we & rd!=0 & cnt[rd]==CNT_MAX.
//  iss_ready_o = !rst_i & !flush_i & !RAW0 & !RAW1 & !SAT. It does not depend on iss_valid_i.
//  Read ports are driven combinationally in the fire cycle; data returns per core_regfile timing.
//  Counter update at clk_i, per register r:
//   - inc = fire & rd_we & rd==r & r!=0.
//   - dec = wb_valid & wb_addr==r & cnt[r]!=0.
//   - inc&dec: unchanged. inc only: +1. dec only: -1.
//   - Registered update: busy_o and pend_total_o reflect it next cycle.
//  Writeback with wb_addr==0, or to a register with cnt==0 (a same-cycle issue to that rd does not count):
//   - set err_o; no counter changes.
//   - err_o clears only on reset.
//  flush_i: all counters to 0 next cycle; writeback and issue in the flush cycle are ignored.
//  x0: never busy; writes to x0 are not tracked; reads of x0 never stall.
//  rs0==rs1==rd is legal. It stalls only if that register is already busy, not on its own rd.
//  Zero-latency turnaround: an rd issued in cycle N blocks dependents from cycle N+1.
// CONFIGURATION
//  SCOREBOARD_BYPASS_EN defined:
//   - RAW on src s is suppressed when wb_valid_i & wb_addr_i==s & cnt[s]==1.
//   - The dependent issues in the writeback cycle.
//   - The regfile/forward path must supply the write-through value.
//  Not defined: the dependent stalls until the cycle after writeback, one extra bubble.
// STRUCTURE
//  core_regfile_pkg holds:
//   - NREGS, AW
//   - typedef logic [AW-1:0] reg_addr_t
//   - typedef logic [CNT_W-1:0] sb_cnt_t
//  Sub-module core_sb_cnt: one saturating up/down counter with inc, dec and clr inputs.
//   - Generated NREGS-1 times (r=1..NREGS-1).
//  Hazard logic and pend_total_o adder are in the top module.
// TESTING
//  1. Issue rd=5 at cycle 0 -> busy_o[5]=1 at cycle 1.
//     Issue rs0=5 at cycle 1 -> iss_ready_o=0.
//     wb 5 at cycle 3 -> ready=1 at cycle 4, or at cycle 3 with BYPASS_EN.
//  2. Three issues to rd=7 (CNT_MAX=3) -> pend_total_o=3.
//     4th issue to rd=7 stalls; one wb to 7 -> ready next cycle.
//  3. Same cycle: issue rd=9 and wb 9, with cnt[9]=1 -> cnt[9] stays 1 and busy_o[9] stays 1.
//  4. wb to 12 with cnt=0, then wb to 0 -> err_o=1 and remains 1; all counters unchanged.
//  5. 4 regs pending, then flush_i with simultaneous wb -> busy_o=0 and pend_total_o=0 next cycle; err_o=0.
//  6. rst_i pulse mid-stall with 3 regs busy -> outputs zero immediately; issue of rs0=rd=x0 accepted.

Source files
------------

// File: rtl/core_regfile_pkg.sv
// Shared types and sizing for the core_regfile issue scoreboard.
// Optional feature macro used by the scoreboard: SCOREBOARD_BYPASS_EN.
package core_regfile_pkg;

  localparam int NREGS   = 32;
  localparam int AW      = $clog2(NREGS);
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [AW-1:0]       reg_addr_t;
  typedef logic [CNT_W-1:0]    sb_cnt_t;
  typedef logic [AW+CNT_W-1:0] pend_total_t;

endpackage

// File: rtl/core_regfile_scoreboard_if.sv
// Issue handshake and writeback completion bundle between decode,
// writeback and the scoreboard. Decode/writeback side is the master.
interface core_regfile_scoreboard_if;
  import core_regfile_pkg::*;

  logic      iss_valid_i;
  logic      iss_ready_o;
  logic      iss_rs0_use_i;
  reg_addr_t iss_rs0_addr_i;
  logic      iss_rs1_use_i;
  reg_addr_t iss_rs1_addr_i;
  logic      iss_rd_we_i;
  reg_addr_t iss_rd_addr_i;
  logic      wb_valid_i;
  reg_addr_t wb_addr_i;

  modport master (
    output iss_valid_i, iss_rs0_use_i, iss_rs0_addr_i, iss_rs1_use_i,
           iss_rs1_addr_i, iss_rd_we_i, iss_rd_addr_i, wb_valid_i, wb_addr_i,
    input  iss_ready_o
  );

  modport slave (
    input  iss_valid_i, iss_rs0_use_i, iss_rs0_addr_i, iss_rs1_use_i,
           iss_rs1_addr_i, iss_rd_we_i, iss_rd_addr_i, wb_valid_i, wb_addr_i,
    output iss_ready_o
  );

endinterface

// File: rtl/core_sb_cnt.sv
// One per-register pending-write counter: saturating up/down with a
// synchronous clear that wins over everything else.
module core_sb_cnt
  import core_regfile_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    clr_i,
  input  logic    inc_i,
  input  logic    dec_i,
  output sb_cnt_t cnt_o
);

  sb_cnt_t cnt_q;
  sb_cnt_t cnt_d;

  // Next count: clear, else +1/-1 when exactly one of inc/dec is set, bounded both ways
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && (cnt_q != sb_cnt_t'(CNT_MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, wiped immediately by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/core_regfile_scoreboard.sv
// Issue-side scoreboard for core_regfile: counts in-flight writes per
// architectural register, stalls issue on RAW hazards or counter
// saturation, and drives the regfile read ports on every accepted issue.
// x0 is never tracked. Optional macro SCOREBOARD_BYPASS_EN lets a dependent
// issue in the same cycle as the last outstanding writeback of its source.
module core_regfile_scoreboard
  import core_regfile_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  core_regfile_scoreboard_if.slave  iss_if,
  output logic                      rs0_re_o,
  output reg_addr_t                 rs0_addr_o,
  output logic                      rs1_re_o,
  output reg_addr_t                 rs1_addr_o,
  output logic [NREGS-1:0]          busy_o,
  output pend_total_t               pend_total_o,
  output logic                      err_o
);

  logic [NREGS-1:0][CNT_W-1:0] cnt_w;
  logic raw0;
  logic raw1;
  logic sat;
  logic ready;
  logic fire;
  logic wb_err;
  logic err_q;
  logic err_d;

  assign cnt_w[0] = '0;

  // Source hazards: a busy non-zero source stalls; with bypass, the final
  // outstanding writeback to that source releases it in the same cycle
  always_comb begin
    raw0 = iss_if.iss_rs0_use_i && (iss_if.iss_rs0_addr_i != '0) &&
           (cnt_w[iss_if.iss_rs0_addr_i] != '0);
    raw1 = iss_if.iss_rs1_use_i && (iss_if.iss_rs1_addr_i != '0) &&
           (cnt_w[iss_if.iss_rs1_addr_i] != '0);
`ifdef SCOREBOARD_BYPASS_EN
    if (iss_if.wb_valid_i && (iss_if.wb_addr_i == iss_if.iss_rs0_addr_i) &&
        (cnt_w[iss_if.iss_rs0_addr_i] == sb_cnt_t'(1))) begin
      raw0 = 1'b0;
    end
    if (iss_if.wb_valid_i && (iss_if.wb_addr_i == iss_if.iss_rs1_addr_i) &&
        (cnt_w[iss_if.iss_rs1_addr_i] == sb_cnt_t'(1))) begin
      raw1 = 1'b0;
    end
`endif
  end

  // Destination saturation, readiness and the fire strobe
  always_comb begin
    sat   = iss_if.iss_rd_we_i && (iss_if.iss_rd_addr_i != '0) &&
            (cnt_w[iss_if.iss_rd_addr_i] == sb_cnt_t'(CNT_MAX));
    ready = !rst_i && !flush_i && !raw0 && !raw1 && !sat;
    fire  = iss_if.iss_valid_i && ready;
  end

  assign iss_if.iss_ready_o = ready;
  assign rs0_re_o   = fire && iss_if.iss_rs0_use_i;
  assign rs0_addr_o = iss_if.iss_rs0_addr_i;
  assign rs1_re_o   = fire && iss_if.iss_rs1_use_i;
  assign rs1_addr_o = iss_if.iss_rs1_addr_i;

  // A writeback with nothing outstanding (or to x0) is a protocol error;
  // a same-cycle issue to that rd does not make it legal
  assign wb_err = iss_if.wb_valid_i && !flush_i &&
                  ((iss_if.wb_addr_i == '0) || (cnt_w[iss_if.wb_addr_i] == '0));

  generate
    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      logic inc_w;
      logic dec_w;
      assign inc_w = fire && iss_if.iss_rd_we_i &&
                     (iss_if.iss_rd_addr_i == reg_addr_t'(r));
      assign dec_w = iss_if.wb_valid_i && !flush_i &&
                     (iss_if.wb_addr_i == reg_addr_t'(r)) && (cnt_w[r] != '0);
      core_sb_cnt u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (inc_w),
        .dec_i (dec_w),
        .cnt_o (cnt_w[r])
      );
    end
  endgenerate

  // Busy flags and the total of all outstanding writes
  always_comb begin
    busy_o       = '0;
    pend_total_o = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_o[r]    = |cnt_w[r];
      pend_total_o = pend_total_o + pend_total_t'(cnt_w[r]);
    end
  end

  assign err_d = err_q || wb_err;

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_core_regfile_scoreboard.sv
// Scoreboard-style bench for core_regfile_scoreboard: the driver computes
// expected outputs from a per-register pending-count model and queues them;
// a monitor pops and compares each cycle. Honours SCOREBOARD_BYPASS_EN.
module tb_core_regfile_scoreboard;
  import core_regfile_pkg::*;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    bit          ready;
    bit          re0;
    bit          re1;
    reg_addr_t   a0;
    reg_addr_t   a1;
    logic [31:0] busy;
    pend_total_t pend;
    bit          err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        rs0_re;
  reg_addr_t   rs0_addr;
  logic        rs1_re;
  reg_addr_t   rs1_addr;
  logic [NREGS-1:0] busy;
  pend_total_t pend_total;
  logic        err;

  core_regfile_scoreboard_if bus ();

  core_regfile_scoreboard dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .iss_if       (bus.slave),
    .rs0_re_o     (rs0_re),
    .rs0_addr_o   (rs0_addr),
    .rs1_re_o     (rs1_re),
    .rs1_addr_o   (rs1_addr),
    .busy_o       (busy),
    .pend_total_o (pend_total),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   model_cnt [NREGS];
  bit   model_err;
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit srcStalls(input bit use_s, input int s, input bit wbv, input int wba);
    if (!use_s || s == 0 || model_cnt[s] == 0) return 1'b0;
    if (BYPASS && wbv && wba == s && model_cnt[s] == 1) return 1'b0;
    return 1'b1;
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, advance the model
  task automatic applyStimulus(input bit r, input bit f, input bit v,
                               input bit u0, input int a0, input bit u1, input int a1,
                               input bit we, input int rd, input bit wbv, input int wba);
    exp_t e;
    bit   rdy;
    bit   sat;
    int   tot;
    @(negedge clk);
    rst                = r;
    flush              = f;
    bus.iss_valid_i    = v;
    bus.iss_rs0_use_i  = u0;
    bus.iss_rs0_addr_i = reg_addr_t'(a0);
    bus.iss_rs1_use_i  = u1;
    bus.iss_rs1_addr_i = reg_addr_t'(a1);
    bus.iss_rd_we_i    = we;
    bus.iss_rd_addr_i  = reg_addr_t'(rd);
    bus.wb_valid_i     = wbv;
    bus.wb_addr_i      = reg_addr_t'(wba);
    if (r) begin
      foreach (model_cnt[i]) model_cnt[i] = 0;
      model_err = 1'b0;
    end
    sat = we && rd != 0 && model_cnt[rd] == CNT_MAX;
    rdy = !r && !f && !srcStalls(u0, a0, wbv, wba) && !srcStalls(u1, a1, wbv, wba) && !sat;
    e.ready = rdy;
    e.re0   = v && rdy && u0;
    e.re1   = v && rdy && u1;
    e.a0    = reg_addr_t'(a0);
    e.a1    = reg_addr_t'(a1);
    tot = 0;
    e.busy = '0;
    for (int i = 0; i < NREGS; i++) begin
      e.busy[i] = (model_cnt[i] != 0);
      tot += model_cnt[i];
    end
    e.pend = pend_total_t'(tot);
    e.err  = model_err;
    exp_q.push_back(e);
    if (!r) begin
      if (f) begin
        foreach (model_cnt[i]) model_cnt[i] = 0;
      end else begin
        if (wbv) begin
          if (wba == 0 || model_cnt[wba] == 0) model_err = 1'b1;
          else model_cnt[wba]--;
        end
        if (v && rdy && we && rd != 0) model_cnt[rd]++;
      end
    end
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare what the DUT presents against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("iss_ready", 64'(bus.iss_ready_o), 64'(e.ready));
        checkOutput("rs0_re", 64'(rs0_re), 64'(e.re0));
        checkOutput("rs1_re", 64'(rs1_re), 64'(e.re1));
        checkOutput("rs0_addr", 64'(rs0_addr), 64'(e.a0));
        checkOutput("rs1_addr", 64'(rs1_addr), 64'(e.a1));
        checkOutput("busy", 64'(busy), 64'(e.busy));
        checkOutput("pend_total", 64'(pend_total), 64'(e.pend));
        checkOutput("err", 64'(err), 64'(e.err));
      end
    end
  end

  initial begin
    int  a0, a1, rd, wba;
    bit  wbv;
    rst = 1'b1;
    flush = 1'b0;
    bus.iss_valid_i = 1'b0;
    bus.iss_rs0_use_i = 1'b0;
    bus.iss_rs0_addr_i = '0;
    bus.iss_rs1_use_i = 1'b0;
    bus.iss_rs1_addr_i = '0;
    bus.iss_rd_we_i = 1'b0;
    bus.iss_rd_addr_i = '0;
    bus.wb_valid_i = 1'b0;
    bus.wb_addr_i = '0;
    foreach (model_cnt[i]) model_cnt[i] = 0;
    model_err = 1'b0;

    $display("[TB] reset and directed sequences (bypass=%0d)", BYPASS);
    applyStimulus(1, 0, 1, 1, 3, 0, 0, 1, 3, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // RAW stall on rd=5 released by its writeback
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    applyStimulus(0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 5, 0, 0, 0, 0, 1, 5);
    applyStimulus(0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    idle();

    // Saturation on rd=7
    repeat (3) applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 7, 1, 7);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    idle();

    // Same-cycle issue and writeback on rd=9 with rs0==rs1==rd
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 9, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 9, 1, 9);
    applyStimulus(0, 0, 1, 1, 9, 1, 9, 1, 9, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    applyStimulus(0, 0, 1, 1, 9, 1, 9, 1, 9, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);

    // Illegal writebacks set the sticky error
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    idle();

    // Flush with a simultaneous writeback
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, i, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 6, 1, 1);
    idle();

    // Reset mid-stall, then an x0 read/write issue
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 10, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 11, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 13, 0, 0);
    applyStimulus(0, 0, 1, 1, 10, 1, 11, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 10, 1, 11, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    idle();

    $display("[TB] randomized phase");
    for (int c = 0; c < 3000; c++) begin
      a0  = $urandom_range(0, 7);
      a1  = $urandom_range(0, 7);
      rd  = $urandom_range(0, 7);
      wba = $urandom_range(0, 7);
      if (model_cnt[wba] > 0) wbv = ($urandom_range(0, 9) < 5);
      else wbv = ($urandom_range(0, 99) < 3);
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 1) == 1, a0, $urandom_range(0, 1) == 1, a1,
                    $urandom_range(0, 3) != 0, rd, wbv, wba);
    end

    @(negedge clk);
    #3;
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
